mips_state_dumper: RTL

- Post-run architectural-state readout engine for the MIPS5 pipelined core; replaces hierarchical register and memory dumps with a synthesizable, parametrised streaming dump.
- Counts a configurable number of run cycles after reset or start, freezes the core, then serially reads register file entries and data-memory words.
- Emits each entry as a tagged word on a valid/ready stream for a UART/trace sink or a bench scoreboard.

---
 rtl/mips_dbg_pkg.sv | 10 +
 rtl/dump_out_reg.sv | 50 +++++
 rtl/mips_state_dumper.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared types for the MIPS5 post-run state dumper: FSM states and output region tags.
package mips_dbg_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DREG, DMEM, CSUM, DONE} state_t;

  localparam logic [1:0] REGION_REG = 2'd0;
  localparam logic [1:0] REGION_MEM = 2'd1;
  localparam logic [1:0] REGION_SUM = 2'd2;

endpackage

// File: rtl/dump_out_reg.sv
// Valid/ready holding register for dump words: captures a word when the slot is free,
// holds it while the sink stalls, and empties on handshake.
module dump_out_reg #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [1:0]        load_region,
  input  logic [IDX_W-1:0]  load_index,
  input  logic              out_ready,
  output logic              slot_free,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_region,
  output logic [IDX_W-1:0]  out_index
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [1:0]        region_reg;
  logic [IDX_W-1:0]  index_reg;

  // Free when empty, or when the current word retires on this edge.
  assign slot_free = !valid_reg || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg  <= 1'b0;
      data_reg   <= '0;
      region_reg <= '0;
      index_reg  <= '0;
    end else if (load && slot_free) begin
      valid_reg  <= 1'b1;
      data_reg   <= load_data;
      region_reg <= load_region;
      index_reg  <= load_index;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid  = valid_reg;
  assign out_data   = data_reg;
  assign out_region = region_reg;
  assign out_index  = index_reg;

endmodule

// File: rtl/mips_state_dumper.sv
// Post-run state dumper: runs the core for RUN_CYCLES, halts it, then streams register and
// memory contents. Define DUMP_CHECKSUM_EN to append a checksum word after the memory region.
module mips_state_dumper
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 12,
  parameter int NUM_MEM    = 12,
  parameter int IDX_W      = 10,
  parameter int RUN_CYCLES = 60,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              auto_en,
  input  logic              start,
  output logic              halt_core,
  output logic [4:0]        reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic [IDX_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_region,
  output logic [IDX_W-1:0]  out_index,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYCLES - 1);
  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(NUM_MEM - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic              first_reg;
  logic              slot_free;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic [1:0]        load_region;
  logic [IDX_W-1:0]  load_index;
`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_reg, sum_next;
`endif

  // first_reg marks the single IDLE cycle right after reset in which auto_en is honoured.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      first_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      first_reg <= 1'b0;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg <= '0;
    end else begin
      sum_reg <= sum_next;
    end
  end
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    load        = 1'b0;
    load_data   = '0;
    load_region = REGION_REG;
    load_index  = idx_reg;
`ifdef DUMP_CHECKSUM_EN
    sum_next    = sum_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start || (first_reg && auto_en)) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      RUN: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = DREG;
          cnt_next   = '0;
          idx_next   = '0;
`ifdef DUMP_CHECKSUM_EN
          sum_next   = '0;
`endif
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DREG: begin
        if (slot_free) begin
          load        = 1'b1;
          load_data   = reg_rd_data;
          load_region = REGION_REG;
`ifdef DUMP_CHECKSUM_EN
          sum_next    = sum_reg + reg_rd_data;
`endif
          if (idx_reg == REG_LAST) begin
            idx_next   = '0;
            state_next = DMEM;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      DMEM: begin
        if (slot_free) begin
          load        = 1'b1;
          load_data   = mem_rd_data;
          load_region = REGION_MEM;
`ifdef DUMP_CHECKSUM_EN
          sum_next    = sum_reg + mem_rd_data;
`endif
          if (idx_reg == MEM_LAST) begin
            idx_next = '0;
`ifdef DUMP_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      CSUM: begin
`ifdef DUMP_CHECKSUM_EN
        if (slot_free) begin
          load        = 1'b1;
          load_data   = sum_reg;
          load_region = REGION_SUM;
          load_index  = '0;
          state_next  = DONE;
        end
`else
        state_next = DONE;
`endif
      end
      DONE: begin
        // A restart must wait until the final word has been taken by the sink.
        if (start && !out_valid) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  dump_out_reg #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_out (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (load_data),
    .load_region(load_region),
    .load_index (load_index),
    .out_ready  (out_ready),
    .slot_free  (slot_free),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_region (out_region),
    .out_index  (out_index)
  );

  assign halt_core   = (state_reg == DREG) || (state_reg == DMEM) ||
                       (state_reg == CSUM) || (state_reg == DONE);
  assign busy        = (state_reg == RUN) || (state_reg == DREG) ||
                       (state_reg == DMEM) || (state_reg == CSUM);
  assign done        = (state_reg == DONE);
  assign reg_rd_addr = (state_reg == DREG) ? idx_reg[4:0] : 5'd0;
  assign mem_rd_addr = (state_reg == DMEM) ? idx_reg : '0;

endmodule
